// File: rtl/compressor_signature.sv
// compressor_signature
//   Compacts the compressor's parallel result bits into a multiple-input
//   signature register (MISR). After an accepted start it ignores SKIP cycles
//   while the harness input shift register fills. It then folds COUNT result
//   words into the signature and holds the result for readout.
//
// Ports
//   clk        in   1      clock, all state on posedge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      one-cycle run request (ignored while busy)
//   din        in   WIDTH  compressor result word {dst16..dst0}
//   busy       out  1      high while skipping or compacting
//   done       out  1      high once a run completes, until the next start
//   signature  out  WIDTH  MISR contents; final value valid while done=1
//   ser_data   out  1      serial signature bit, MSB first      (SIG_SERIAL_OUT_EN)
//   ser_valid  out  1      ser_data valid                       (SIG_SERIAL_OUT_EN)
//   ser_ready  in   1      consumer accepts ser_data            (SIG_SERIAL_OUT_EN)
//
// Build option
//   SIG_SERIAL_OUT_EN : adds a serial readout shifter loaded on entry to DONE.
module compressor_signature #(
  parameter int unsigned       WIDTH = 17,
  parameter int unsigned       SKIP  = 13,
  parameter int unsigned       COUNT = 256,
  parameter logic [WIDTH-1:0]  POLY  = 17'h00009,
  parameter logic [WIDTH-1:0]  SEED  = 17'h00001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
`ifdef SIG_SERIAL_OUT_EN
  ,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready
`endif
);

  localparam int unsigned MAXC = (SKIP > COUNT) ? SKIP : COUNT;
  localparam int unsigned CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SKIP_LD = CW'((SKIP == 0) ? 0 : SKIP - 1);
  localparam logic [CW-1:0] RUN_LD  = CW'(COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             start_acc;

  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sig_q   <= SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // Next-state and MISR step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          sig_d = SEED;
          if (SKIP == 0) begin
            state_d = S_RUN;
            cnt_d   = RUN_LD;
          end else begin
            state_d = S_SKIP;
            cnt_d   = SKIP_LD;
          end
        end
      end
      S_SKIP: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = RUN_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == S_SKIP) || (state_q == S_RUN);
    done      = (state_q == S_DONE);
    signature = sig_q;
  end

`ifdef SIG_SERIAL_OUT_EN
  localparam int unsigned SW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_q;
  logic [SW-1:0]    rem_q;
  logic             sval_q;

  // Loads on the RUN->DONE edge using sig_d, so the first bit is presented
  // in the same cycle done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      rem_q   <= '0;
      sval_q  <= 1'b0;
    end else if (start_acc) begin
      sval_q  <= 1'b0;
      rem_q   <= '0;
    end else if (state_q == S_RUN && state_d == S_DONE) begin
      shift_q <= sig_d;
      rem_q   <= SW'(WIDTH);
      sval_q  <= 1'b1;
    end else if (sval_q && ser_ready) begin
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      rem_q   <= rem_q - SW'(1);
      if (rem_q == SW'(1)) begin
        sval_q <= 1'b0;
      end
    end
  end

  always_comb begin
    ser_data  = shift_q[WIDTH-1];
    ser_valid = sval_q;
  end
`endif

endmodule

// File: tb/tb_compressor_signature.sv
module tb_compressor_signature;

  localparam int W       = 17;
  localparam int SKIP_A  = 13;
  localparam int COUNT_A = 17;
  localparam logic [W-1:0] POLY = 17'h00009;
  localparam logic [W-1:0] SEED = 17'h00001;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [W-1:0] din_a   = '0;
  logic [W-1:0] din_b   = '0;
  logic         busy_a, done_a, busy_b, done_b;
  logic [W-1:0] sig_a, sig_b;
`ifdef SIG_SERIAL_OUT_EN
  logic         ser_data_a, ser_valid_a, ser_data_b, ser_valid_b;
  logic         ser_ready_a = 1'b0;
  logic         ser_ready_b = 1'b1;
`endif

  int  n_total = 0;
  int  n_pass  = 0;
  bit  cmp_en  = 1'b0;

  always #5 clk = ~clk;

  compressor_signature #(
    .WIDTH(W), .SKIP(SKIP_A), .COUNT(COUNT_A), .POLY(POLY), .SEED(SEED)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .din(din_a),
    .busy(busy_a), .done(done_a), .signature(sig_a)
`ifdef SIG_SERIAL_OUT_EN
    , .ser_data(ser_data_a), .ser_valid(ser_valid_a), .ser_ready(ser_ready_a)
`endif
  );

  compressor_signature #(
    .WIDTH(W), .SKIP(0), .COUNT(1), .POLY(POLY), .SEED(SEED)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .din(din_b),
    .busy(busy_b), .done(done_b), .signature(sig_b)
`ifdef SIG_SERIAL_OUT_EN
    , .ser_data(ser_data_b), .ser_valid(ser_valid_b), .ser_ready(ser_ready_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Signature arithmetic: multiply by x modulo x^17+x^3+1, then add the input word.
  function automatic logic [W-1:0] mstep(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ {1'b1, POLY};
    return t[W-1:0] ^ d;
  endfunction

  // Reference for dut_a: counts edges elapsed since the accepted start.
  logic         m_active = 1'b0;
  logic         m_done   = 1'b0;
  int           m_t      = 0;
  logic [W-1:0] m_sig    = SEED;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_t <= 0; m_sig <= SEED;
    end else if (!m_active) begin
      if (start_a) begin
        m_active <= 1'b1; m_done <= 1'b0; m_t <= 0; m_sig <= SEED;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 > SKIP_A) m_sig <= mstep(m_sig, din_a);
      if (m_t + 1 == SKIP_A + COUNT_A) begin
        m_active <= 1'b0; m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", {31'b0, busy_a}, {31'b0, m_active});
      check("done", {31'b0, done_a}, {31'b0, m_done});
      check("signature", {15'b0, sig_a}, {15'b0, m_sig});
    end
  end

  // One run on dut_a. din is all-ones for the skip window when directed,
  // zero afterwards; start is re-pulsed after edge k+restart_at when >= 0.
  task automatic run_a(input int restart_at, input bit directed,
                       output int done_at, output int busy_cnt);
    @(negedge clk);
    start_a = 1'b1;
    din_a   = directed ? '1 : W'($urandom);
    done_at  = -1;
    busy_cnt = 0;
    for (int i = 0; i <= 60 && done_at < 0; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (done_a) done_at = i;
      start_a = (i == restart_at);
      din_a   = directed ? ((i < SKIP_A) ? '1 : '0) : W'($urandom);
    end
    start_a = 1'b0;
  endtask

  int done_at, busy_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy_a", {31'b0, busy_a}, 32'd0);
    check("rst_done_a", {31'b0, done_a}, 32'd0);
    check("rst_sig_a", {15'b0, sig_a}, 32'h00001);
    check("rst_sig_b", {15'b0, sig_b}, 32'h00001);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // SKIP=0, COUNT=1 instance
    @(negedge clk); start_b = 1'b1; din_b = '0;
    @(negedge clk); start_b = 1'b0;
    check("b_busy", {31'b0, busy_b}, 32'd1);
    check("b_done_early", {31'b0, done_b}, 32'd0);
    @(negedge clk);
    check("b_done", {31'b0, done_b}, 32'd1);
    check("b_sig_zero", {15'b0, sig_b}, 32'h00002);
    check("b_busy_off", {31'b0, busy_b}, 32'd0);
    din_b = '1; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("b_reseed", {15'b0, sig_b}, 32'h00001);
    check("b_done_drop", {31'b0, done_b}, 32'd0);
    @(negedge clk);
    check("b_sig_ones", {15'b0, sig_b}, 32'h1FFFD);
    check("b_done2", {31'b0, done_b}, 32'd1);

    // Skip window ignored; x^17 mod poly
    run_a(-1, 1'b1, done_at, busy_cnt);
    check("a_done_edge", done_at, 32'd30);
    check("a_busy_cycles", busy_cnt, 32'd30);
    check("a_sig_9", {15'b0, sig_a}, 32'h00009);
    check("model_sig_9", {15'b0, m_sig}, 32'h00009);

`ifdef SIG_SERIAL_OUT_EN
    begin
      logic [W-1:0] exp_ser;
      int nbits;
      exp_ser = 17'h00009;
      nbits   = 0;
      for (int i = 0; i < 100 && nbits < W; i++) begin
        @(negedge clk);
        check("ser_valid", {31'b0, ser_valid_a}, 32'd1);
        check("ser_bit", {31'b0, ser_data_a}, {31'b0, exp_ser[W-1-nbits]});
        if (ser_ready_a) nbits++;
        ser_ready_a = (i % 2 == 0);
        if (ser_ready_a == 1'b0) begin
          // bit stays put across a stall
        end
      end
      @(negedge clk);
      ser_ready_a = 1'b0;
      if (ser_valid_a && nbits < W) nbits++;
      @(negedge clk);
      check("ser_count", nbits, W);
      check("ser_valid_end", {31'b0, ser_valid_a}, 32'd0);
    end
`endif

    // Start while busy is ignored
    run_a(20, 1'b0, done_at, busy_cnt);
    check("a_restart_done_edge", done_at, 32'd30);
    check("a_restart_busy", busy_cnt, 32'd30);

    // Asynchronous reset mid-run
    @(negedge clk); start_a = 1'b1; din_a = W'($urandom);
    @(negedge clk); start_a = 1'b0;
    repeat (18) begin din_a = W'($urandom); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy_a}, 32'd0);
    check("arst_done", {31'b0, done_a}, 32'd0);
    check("arst_sig", {15'b0, sig_a}, 32'h00001);
    @(negedge clk); rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start_a = ($urandom_range(0, 9) == 0);
      din_a   = W'($urandom);
`ifdef SIG_SERIAL_OUT_EN
      ser_ready_a = 1'($urandom_range(0, 1));
`endif
    end
    start_a = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
